// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick-driven interval timer.
package tick_timer_pkg;

    localparam int unsigned TT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/tick_timer_if.sv
// Command/status bundle between a controller and the tick_timer.
interface tick_timer_if
    import tick_timer_pkg::*;
#(
    parameter int unsigned WIDTH = TT_WIDTH
) ();

    logic             start;
    logic             stop;
    logic             reload_en;
    logic [WIDTH-1:0] period;
    logic             busy;
    logic             hold;
    logic [WIDTH-1:0] cnt;
    logic             done;

    modport master (
        output start, stop, reload_en, period,
        input  busy, hold, cnt, done
    );

    modport slave (
        input  start, stop, reload_en, period,
        output busy, hold, cnt, done
    );

endinterface

// File: rtl/tick_rise_det.sv
// Rising-edge detector for the divider tick, used as a same-domain enable.
module tick_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    output logic tick_rise
);

    logic tick_prev_q;
    logic tick_prev_d;

    always_comb tick_prev_d = tick_in;

    // Resets high: the divider parks its tick high while cleared, so that level is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_prev_q <= 1'b1;
        else     tick_prev_q <= tick_prev_d;
    end

    assign tick_rise = tick_in & ~tick_prev_q;

endmodule

// File: rtl/tick_timer.sv
// Programmable interval timer counting divider tick edges, with one-shot/auto-reload and pause.
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int unsigned WIDTH = TT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_in,
    tick_timer_if.slave   bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             reload_q, reload_d;
    logic             done_q, done_d;
    logic             tick_rise;
    logic             start_ok;

    tick_rise_det u_rise (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .tick_rise (tick_rise)
    );

    assign start_ok = bus.start && (bus.period != '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!bus.stop && start_ok) begin
                    state_d  = ST_RUN;
                    cnt_d    = bus.period;
                    period_d = bus.period;
                    reload_d = bus.reload_en;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_HOLD;
                end else if (start_ok) begin
                    cnt_d    = bus.period;
                    period_d = bus.period;
                    reload_d = bus.reload_en;
                end else if (tick_rise) begin
                    if (cnt_q > WIDTH'(1)) begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end else if (cnt_q == WIDTH'(1)) begin
                        done_d = 1'b1;
                        if (reload_q) begin
                            cnt_d = period_q;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            reload_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.hold = (state_q == ST_HOLD);
    assign bus.cnt  = cnt_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer against a behavioural interval model.
module tb_tick_timer;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    logic tick_in;

    tick_timer_if #(.WIDTH(W)) tif ();

    tick_timer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .bus     (tif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an interval is "remaining edges" plus running/paused flags.
    bit m_prev, m_busy, m_paused, m_done, m_auto;
    int m_cnt, m_per;

    task automatic model_reset();
        m_prev = 1'b1; m_busy = 1'b0; m_paused = 1'b0; m_done = 1'b0;
        m_auto = 1'b0; m_cnt = 0; m_per = 0;
    endtask

    task automatic model_edge();
        bit rise;
        rise   = tick_in && !m_prev;
        m_prev = tick_in;
        m_done = 1'b0;
        if (!m_busy) begin
            if (tif.start && !tif.stop && tif.period != 0) begin
                m_busy = 1'b1; m_cnt = tif.period; m_per = tif.period; m_auto = tif.reload_en;
            end
        end else if (m_paused) begin
            if (tif.stop) begin
                m_busy = 1'b0; m_paused = 1'b0; m_cnt = 0;
            end else if (tif.start) begin
                m_paused = 1'b0;
            end
        end else if (tif.stop) begin
            m_paused = 1'b1;
        end else if (tif.start && tif.period != 0) begin
            m_cnt = tif.period; m_per = tif.period; m_auto = tif.reload_en;
        end else if (rise && m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_done = 1'b1;
                if (m_auto) m_cnt = m_per;
                else        m_busy = 1'b0;
            end
        end
    endtask

    function automatic logic [W+2:0] exp_vec();
        return {m_busy, m_paused, m_done, W'(m_cnt)};
    endfunction

    function automatic logic [W+2:0] obs_vec();
        return {tif.busy, tif.hold, tif.done, tif.cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        tif.start = 1'b0;
        tif.stop  = 1'b0;
    endtask

    task automatic issue_start(input int p, input bit rl);
        tif.period = W'(p); tif.reload_en = rl; tif.start = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL reset_async: got %h expected %h", obs_vec(), 11'h0);
        end
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_release c=%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_oneshot();
        int dones = 0;
        bit busy_fell_with_done = 1'b0;
        issue_start(3, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec() || tif.cnt !== W'(3)) begin
            errors++; $display("FAIL oneshot_load: got %h expected %h", obs_vec(), exp_vec());
        end
        for (int c = 0; c < 25; c++) begin
            tick_in = (c % 5 == 4);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL oneshot c=%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            if (tif.done) begin
                dones++;
                if (!tif.busy && tif.cnt == 0) busy_fell_with_done = 1'b1;
            end
        end
        checks++;
        if (dones != 1 || !busy_fell_with_done) begin
            errors++; $display("FAIL oneshot_done: got dones=%0d busy_fell=%0d expected dones=1 busy_fell=1", dones, busy_fell_with_done);
        end
    endtask

    task automatic test_autoreload();
        int done_at[$];
        issue_start(2, 1'b1);
        for (int c = 0; c < 30; c++) begin
            tick_in = (c % 5 == 4);
            step();
            checks++;
            if (obs_vec() !== exp_vec() || tif.busy !== 1'b1) begin
                errors++; $display("FAIL autoreload c=%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            if (tif.done) done_at.push_back(c);
        end
        checks++;
        if (done_at.size() != 3 || done_at[1] - done_at[0] != 10 || done_at[2] - done_at[1] != 10) begin
            errors++; $display("FAIL autoreload_spacing: got %0d pulses expected 3 pulses 10 apart", done_at.size());
        end
        tif.stop = 1'b1; step();
        tif.stop = 1'b1; step();
    endtask

    task automatic test_hold_resume();
        int dones = 0;
        issue_start(4, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick_in = (c % 5 == 4);
            step();
        end
        tif.stop = 1'b1; step();
        for (int c = 0; c < 15; c++) begin
            tick_in = (c % 5 == 2);
            step();
            checks++;
            if (tif.cnt !== W'(2) || tif.hold !== 1'b1 || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL hold_frozen c=%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        tif.start = 1'b1; tif.period = W'(9); step();
        for (int c = 0; c < 10; c++) begin
            tick_in = (c % 5 == 4);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL resume c=%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            if (tif.done) dones++;
        end
        checks++;
        if (dones != 1 || tif.busy !== 1'b0) begin
            errors++; $display("FAIL resume_done: got dones=%0d busy=%0b expected 1 and 0", dones, tif.busy);
        end
    endtask

    task automatic test_abort();
        issue_start(5, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick_in = (c % 5 == 4);
            step();
        end
        tif.stop = 1'b1; step();
        tif.stop = 1'b1; step();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs_vec() !== '0 || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL abort c=%0d: got %h expected %h", c, obs_vec(), 11'h0);
            end
            tick_in = (c == 1);
            step();
        end
    endtask

    task automatic test_idle_ignores();
        issue_start(0, 1'b1);
        checks++;
        if (tif.busy !== 1'b0 || tif.done !== 1'b0) begin
            errors++; $display("FAIL zero_period: got busy=%0b done=%0b expected 0 0", tif.busy, tif.done);
        end
        tif.stop = 1'b1;
        issue_start(7, 1'b0);
        checks++;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL start_stop_idle: got %h expected %h", obs_vec(), 11'h0);
        end
    endtask

    task automatic test_reset_mid();
        issue_start(2, 1'b0);
        tick_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick_in = (c == 4);
            step();
        end
        tick_in = 1'b0;
        step();
        checks++;
        if (tif.cnt !== W'(1) || tif.busy !== 1'b1) begin
            errors++; $display("FAIL reset_mid_setup: got cnt=%0d busy=%0b expected 1 1", tif.cnt, tif.busy);
        end
        tick_in = 1'b1;
        #1 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL reset_mid_async: got %h expected %h", obs_vec(), 11'h0);
        end
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (tif.done !== 1'b0 || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_mid_after c=%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        issue_start($urandom_range(1, 6), 1'b1);
        for (int c = 0; c < 40; c++) begin
            tick_in = c[0];
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL back_to_back c=%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            tick_in       = 1'($urandom_range(0, 1));
            tif.start     = ($urandom_range(0, 19) == 0);
            tif.stop      = ($urandom_range(0, 24) == 0);
            tif.period    = W'($urandom_range(0, 6));
            tif.reload_en = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random c=%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        tick_in = 1'b1;
        tif.start = 1'b0; tif.stop = 1'b0; tif.reload_en = 1'b0; tif.period = '0;
        model_reset();
        test_reset();
        test_oneshot();
        test_autoreload();
        test_hold_resume();
        test_abort();
        test_idle_ignores();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
